// File: rtl/i2c_master_write_frame.sv
// Purpose : I2C master transmitter; one `go` sends START, up to DATA_BYTES bytes each with an ACK slot, then STOP.
// Latency : outputs follow the accept edge by one clock; the frame runs 4*DIV*(2+9*N) clocks until `finish`.
// Backpr. : no flow control; `go` is honoured only in IDLE and ignored while busy or in the DONE cycle.
//
// Ports   : clock, reset_n (synchronous, active low); go, data, byte_num request a frame;
//           sda_in is the sampled bus SDA; scl/sda are open-drain drives (1 = released);
//           busy, finish, nack and bytes_sent report frame status.
// Option  : define I2C_WRITE_FRAME_NACK_ABORT_EN to end the frame with STOP on the first NACK.
module i2c_master_write_frame #(
    parameter int DATA_BYTES = 2,
    parameter int DIV        = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            go,
    input  logic [8*DATA_BYTES-1:0]         data,
    input  logic [$clog2(DATA_BYTES+1)-1:0] byte_num,
    input  logic                            sda_in,
    output logic                            scl,
    output logic                            sda,
    output logic                            busy,
    output logic                            finish,
    output logic                            nack,
    output logic [$clog2(DATA_BYTES+1)-1:0] bytes_sent
);

    localparam int              BW   = $clog2(DATA_BYTES + 1);
    localparam int              QW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0]   QMAX = QW'(DIV - 1);
    localparam logic [BW-1:0]   BMAX = BW'(DATA_BYTES);
`ifdef I2C_WRITE_FRAME_NACK_ABORT_EN
    localparam bit              ABORT_ON_NACK = 1'b1;
`else
    localparam bit              ABORT_ON_NACK = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [QW-1:0]           qcnt, qcnt_nxt;
    logic [1:0]              phase, phase_nxt;
    logic [2:0]              bit_cnt, bit_cnt_nxt;
    logic [8*DATA_BYTES-1:0] shreg, shreg_nxt;
    logic [BW-1:0]           n_lat;
    logic [BW-1:0]           sent_inc;
    logic                    slot_end;
    logic                    accept;
    logic                    ack_sample;
    logic                    scl_nxt;
    logic                    sda_nxt;

    assign slot_end   = (phase == 2'd3) && (qcnt == QMAX);
    assign accept     = (state == S_IDLE) && go;
    assign ack_sample = (state == S_ACK) && (phase == 2'd2) && (qcnt == QMAX);
    assign sent_inc   = bytes_sent + BW'(1);

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_START;
            S_START: if (slot_end) state_nxt = (n_lat == '0) ? S_STOP : S_DATA;
            S_DATA:  if (slot_end && (bit_cnt == 3'd0)) state_nxt = S_ACK;
            S_ACK: begin
                // nack was captured at the end of q2, so it is settled by slot end
                if (slot_end) begin
                    if ((ABORT_ON_NACK && nack) || !(sent_inc < n_lat)) state_nxt = S_STOP;
                    else                                                state_nxt = S_DATA;
                end
            end
            S_STOP:  if (slot_end) state_nxt = S_STOP == state ? S_DONE : S_STOP;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divider, bit counter and payload shifter next values. Every state change other
    // than IDLE->START happens at a slot end, so clearing there covers "clear on entry".
    always_comb begin
        qcnt_nxt    = qcnt;
        phase_nxt   = phase;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        if ((state == S_IDLE) || (state == S_DONE) || slot_end) begin
            qcnt_nxt  = '0;
            phase_nxt = 2'd0;
        end else if (qcnt == QMAX) begin
            qcnt_nxt  = '0;
            phase_nxt = phase + 2'd1;
        end else begin
            qcnt_nxt  = qcnt + QW'(1);
        end
        if ((state_nxt == S_DATA) && (state != S_DATA)) begin
            bit_cnt_nxt = 3'd7;
        end else if ((state == S_DATA) && slot_end) begin
            bit_cnt_nxt = bit_cnt - 3'd1;
        end
        // The byte being sent always sits in shreg[7:0]
        if (accept) begin
            shreg_nxt = data;
        end else if ((state == S_ACK) && slot_end) begin
            shreg_nxt = shreg >> 8;
        end
    end

    // Output decode from the next state/phase so the registered pins line up with the state
    always_comb begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b1;
        case (state_nxt)
            S_START: begin
                scl_nxt = (phase_nxt != 2'd3);
                sda_nxt = !phase_nxt[1];
            end
            S_DATA: begin
                scl_nxt = phase_nxt[1];
                sda_nxt = shreg_nxt[bit_cnt_nxt];
            end
            S_ACK: begin
                scl_nxt = phase_nxt[1];
                sda_nxt = 1'b1;
            end
            S_STOP: begin
                scl_nxt = (phase_nxt != 2'd0);
                sda_nxt = phase_nxt[1];
            end
            default: begin
                scl_nxt = 1'b1;
                sda_nxt = 1'b1;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            qcnt       <= '0;
            phase      <= 2'd0;
            bit_cnt    <= 3'd0;
            shreg      <= '0;
            n_lat      <= '0;
            scl        <= 1'b1;
            sda        <= 1'b1;
            busy       <= 1'b0;
            finish     <= 1'b0;
            nack       <= 1'b0;
            bytes_sent <= '0;
        end else begin
            qcnt    <= qcnt_nxt;
            phase   <= phase_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            scl     <= scl_nxt;
            sda     <= sda_nxt;
            busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            finish  <= (state_nxt == S_DONE);
            if (accept) begin
                n_lat      <= (byte_num > BMAX) ? BMAX : byte_num;
                nack       <= 1'b0;
                bytes_sent <= '0;
            end else begin
                if (ack_sample && sda_in) nack <= 1'b1;
                if ((state == S_ACK) && slot_end) bytes_sent <= sent_inc;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_write_frame.sv
module tb_i2c_master_write_frame;

    localparam int DB = 2;
    localparam int DV = 2;
    localparam int BW = $clog2(DB + 1);

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            go = 1'b0;
    logic [8*DB-1:0] data = '0;
    logic [BW-1:0]   byte_num = '0;
    logic            sda_in;
    logic            scl, sda, busy, finish, nack;
    logic [BW-1:0]   bytes_sent;

    i2c_master_write_frame #(.DATA_BYTES(DB), .DIV(DV)) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .data(data), .byte_num(byte_num),
        .sda_in(sda_in), .scl(scl), .sda(sda), .busy(busy), .finish(finish),
        .nack(nack), .bytes_sent(bytes_sent)
    );

    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Bus monitor: records SDA at every SCL rise, counts START/STOP conditions
    logic prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
    bit   mon_bits[$];
    int   rise_cnt = 0, start_cnt = 0, stop_cnt = 0;
    logic resp [0:3];
    logic [1:0] ack_idx;

    always @(negedge clock) begin
        if (busy && !prev_busy) begin
            mon_bits.delete();
            rise_cnt  = 0;
            start_cnt = 0;
            stop_cnt  = 0;
        end
        if (busy) begin
            if (!prev_scl && scl) begin
                mon_bits.push_back(sda);
                rise_cnt++;
            end
            if (prev_scl && scl && prev_sda && !sda) start_cnt++;
            if (prev_scl && scl && !prev_sda && sda) stop_cnt++;
        end
        prev_scl  = scl;
        prev_sda  = sda;
        prev_busy = busy;
    end

    // Slave response: the 9th SCL rise of each byte is its ACK slot
    always_comb ack_idx = 2'((rise_cnt == 0) ? 0 : (rise_cnt - 1) / 9);
    assign sda_in = resp[ack_idx];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input logic [15:0] d, input int n, input logic [3:0] r, input bit poke);
        int  nn, sent, exp_len, t0, t1;
        bit  exp_nack, done, ok;
        bit  exp_bits[$];
        nn = (n > DB) ? DB : n;
        for (int i = 0; i < 4; i++) resp[i] = r[i];
        // Reference: every sent byte is 8 bits MSB first plus a released ACK bit;
        // STOP adds one low SDA sample at its SCL rise.
        sent = 0;
        exp_nack = 1'b0;
        for (int b = 0; b < nn; b++) begin
            sent++;
            for (int i = 7; i >= 0; i--) exp_bits.push_back(d[8*b+i]);
            exp_bits.push_back(1'b1);
            if (r[b]) begin
                exp_nack = 1'b1;
`ifdef I2C_WRITE_FRAME_NACK_ABORT_EN
                break;
`endif
            end
        end
        exp_bits.push_back(1'b0);
        exp_len = 4 * DV * (2 + 9 * sent);

        @(negedge clock);
        data = d;
        byte_num = BW'(n);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        t0 = cyc;
        t1 = 0;
        chk("busy_on_accept", busy, 1);
        chk("start_q0_scl", scl, 1);
        chk("start_q0_sda", sda, 1);
        done = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clock);
            if (poke && c == 20) go = 1'b1;
            if (poke && c == 21) go = 1'b0;
            if (finish) begin
                done = 1'b1;
                t1 = cyc;
            end
        end
        chk("finish_seen", done, 1);
        chk("frame_len", t1 - t0, exp_len);
        chk("busy_at_finish", busy, 0);
        chk("nack", nack, exp_nack);
        chk("bytes_sent", bytes_sent, sent);
        chk("bit_count", mon_bits.size(), exp_bits.size());
        ok = (mon_bits.size() == exp_bits.size());
        for (int i = 0; i < mon_bits.size() && ok; i++) if (mon_bits[i] != exp_bits[i]) ok = 1'b0;
        chk("bit_seq", ok, 1);
        chk("start_cnt", start_cnt, 1);
        chk("stop_cnt", stop_cnt, 1);
        if (poke) go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        chk("finish_one_cycle", finish, 0);
        chk("idle_after_done", busy, 0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) resp[i] = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda, 1);
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_nack", nack, 0);
        chk("rst_bytes", bytes_sent, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        run_frame(16'h3CA5, 2, 4'b0000, 1'b0);
        run_frame(16'h3CA5, 2, 4'b0001, 1'b1);
        run_frame(16'h00FF, 0, 4'b0000, 1'b0);
        run_frame(16'($urandom), 3, 4'($urandom_range(0, 15)), 1'b1);

        // Reset in the middle of byte 0
        @(negedge clock);
        data = 16'h5A5A;
        byte_num = BW'(2);
        go = 1'b1;
        @(negedge clock);
        go = 1'b0;
        repeat (30) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_finish", finish, 0);
        chk("midrst_nack", nack, 0);
        reset_n = 1'b1;
        @(negedge clock);
        run_frame(16'hC381, 2, 4'b0010, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(0, 3);
            run_frame(16'($urandom), n, 4'($urandom_range(0, 15)), (n > 0) && ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
